instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Front end that feeds the controller: fetches 32-bit words from instruction memory over a req/ack
//  handshake, buffers them in a small prefetch FIFO and issues one instruction per accepted handshake.
//  Issued instruction carries the op/funct fields the controller decodes.
//  Controller's branch/jump outcome returns here as a redirect that flushes the buffer and restarts fetch.
//  Sits between instruction memory and the controller/datapath pair.
// PARAMETERS
//  N        32  instruction/address width
//  DEPTH    4   prefetch FIFO entries (power of 2, >=2)
//  RESET_PC 0   first fetch address after reset
// PORTS
//  clk             in   1   single clock, rising edge
//  reset           in   1   asynchronous, active-high
//  imem_req        out  1   fetch request; held with stable imem_addr until imem_ack
//  imem_addr       out  N   byte address of requested word
//  imem_ack        in   1   one-cycle pulse; imem_rdata valid this cycle
//  imem_rdata      in   N   fetched instruction word
//  issue_valid     out  1   instr/op/funct/issue_pc valid (FIFO head)
//  issue_ready     in   1   downstream accepts head this cycle
//  instr           out  N   head instruction word
//  op              out  4   instr[31:28], to controller op
//  funct           out  4   instr[3:0], to controller funct
//  issue_pc        out  N   address the head word was fetched from
//  redirect        in   1   taken branch or jump (pcsrc | jump)
//  redirect_target in   N   new fetch address, word-aligned
// BEHAVIOUR
//  Reset (async): imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO empty, issue_valid=0,
//   instr/op/funct/issue_pc=0, state=IDLE. Reset mid-request drops it; a later ack is ignored.
//  FSM IDLE/REQ/DRAIN:
//   IDLE : if FIFO has a free slot -> assert imem_req, imem_addr=fetch_pc, go REQ.
//   REQ  : on ack -> push {fetch_pc, imem_rdata}, fetch_pc+=4 (mod 2^N wrap), go IDLE
//          (next req is issued the following cycle, so at most one request is outstanding).
//   DRAIN: req still held at the old address; on ack -> data discarded, go IDLE.
//  Free-slot test counts the outstanding request, so an ack never finds the FIFO full.
//  Issue: issue_valid = !empty; head popped when issue_valid & issue_ready; outputs come from the head
//   (read is combinational from registered storage). Ack-to-issue_valid latency is 1 cycle.
//  Redirect (sampled each edge) has the highest priority:
//   - FIFO flushed (count=0); any same-cycle pop or push is discarded.
//   - fetch_pc=redirect_target.
//   - In REQ without ack -> DRAIN (the request cannot be abandoned). In REQ with ack, or IDLE -> IDLE.
//   - Redirect in DRAIN: only updates the target; the pending ack is still discarded.
//  First fetch after redirect asserts req in the cycle after the redirect edge, or the cycle after the
//   drain ack.
//  Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
//  issue_valid must not depend combinationally on issue_ready.
// STRUCTURE
//  fetch_pkg: OP_MSB/OP_LSB/FUNCT_MSB/FUNCT_LSB field constants, fetch_state_t enum
//   {IDLE,REQ,DRAIN}, fetch_entry_t struct {pc, instr}. Controller and testbench import the field
//   constants from here.
//  Sub-module fetch_fifo: DEPTH x fetch_entry_t, with push, pop, flush, full, empty and count.
//   Flush has priority over push and pop.
//  Top level holds the FSM, fetch_pc, the free-slot logic and the field slicing.
// TESTING
//  1 Reset, zero-wait memory (ack the cycle after req), ready=1 -> addrs 0,4,8..; issue_pc tracks;
//    word 0x2000_0005 gives op=2 funct=5.
//  2 ready=0 -> exactly DEPTH=4 entries held, imem_req low after 4th ack; raise ready -> 4 issues
//    in order, fetch resumes.
//  3 Memory latency 3 cycles, redirect to 0x100 mid-REQ -> ack data dropped, FIFO empty, next
//    req addr=0x100, first issue_pc=0x100.
//  4 Redirect on same edge as pop and ack -> nothing issued or pushed from old stream, fetch_pc=target.
//  5 redirect_target=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000 (wrap).
//  6 Assert reset while REQ outstanding, ack arrives during reset -> outputs at reset values,
//    first post-reset req to RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and instruction field positions for the fetch front end.
// Field constants are also used by the controller when it decodes op/funct.
package fetch_pkg;

  localparam int XLEN      = 32;
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 28;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instr} entries with a combinational head read.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_count,
  output fetch_entry_t o_head
);

  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop && !i_flush && !o_empty;
  assign w_push = i_push && !i_flush && (!o_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: one outstanding memory request at a time, prefetch buffer,
// head-of-buffer issue, and redirect that flushes and restarts the stream.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int            N        = 32,
  parameter int            DEPTH    = 4,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         issue_valid,
  input  logic         issue_ready,
  output logic [N-1:0] instr,
  output logic [3:0]   op,
  output logic [3:0]   funct,
  output logic [N-1:0] issue_pc,
  input  logic         redirect,
  input  logic [N-1:0] redirect_target
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  // state | meaning
  // IDLE  | no request outstanding; issue one when a slot is free
  // REQ   | request outstanding, its data belongs to the live stream
  // DRAIN | request outstanding but redirected away; its data is dropped
  fetch_state_t r_state;
  logic [N-1:0] r_fetch_pc;
  logic [N-1:0] r_imem_addr;
  logic         r_imem_req;

  logic         w_full;
  logic         w_empty;
  logic [AW:0]  w_count;
  logic         w_free;
  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;
  logic [N-1:0] w_instr;

  assign w_push  = (r_state == REQ) && imem_ack;
  assign w_pop   = !w_empty && issue_ready;
  assign w_entry = '{pc: r_imem_addr, instr: imem_rdata};

  // A live request already owns a slot, so it counts toward occupancy.
  assign w_free = !w_full && ((w_count + (AW + 1)'(r_imem_req)) < CNT_FULL);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_fetch_pc  <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect) begin
            r_fetch_pc <= redirect_target;
          end else if (w_free) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fetch_pc;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_state    <= IDLE;
            r_fetch_pc <= redirect ? redirect_target : r_fetch_pc + N'(4);
          end else if (redirect) begin
            r_fetch_pc <= redirect_target;
            r_state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect) r_fetch_pc <= redirect_target;
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_imem_req <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign issue_valid = !w_empty;

  // Outputs read as zero while nothing is buffered.
  assign w_instr  = w_empty ? '0 : w_head.instr;
  assign instr    = w_instr;
  assign issue_pc = w_empty ? '0 : w_head.pc;
  assign op       = w_instr[OP_MSB:OP_LSB];
  assign funct    = w_instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch with a queue-based reference model
// of the fetch stream, plus directed scenarios for redirect, full buffer and reset.
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [31:0] instr;
  logic [3:0]  op;
  logic [3:0]  funct;
  logic [31:0] issue_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;

  always #5 clk = ~clk;

  instruction_fetch #(.N(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .instr           (instr),
    .op              (op),
    .funct           (funct),
    .issue_pc        (issue_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target)
  );

  int n_tests = 0;
  int n_fail  = 0;

  fetch_entry_t q[$];
  logic [31:0]  issued[$];
  logic [31:0]  exp_pc = '0;
  logic [31:0]  held = '0;
  bit           stale = 0;
  bit           active = 0;
  int           mem_cnt = 0;
  int           lat_cfg = 1;
  int           ready_pct = 100;
  int           redir_pct = 0;
  int           redir_mode = 0;
  logic [31:0]  redir_tgt = '0;
  bit           redir_hit = 0;
  logic [31:0]  salt;
  logic [7:0]   seen_op8 = '0;
  logic [31:0]  base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h2000_0005;
    return (a * 32'h9E37_79B9) ^ salt;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    if (i < issued.size()) return issued[i];
    return 32'hDEAD_DEAD;
  endfunction

  // One clock: compare at negedge, drive inputs, advance the model, wait for the edge.
  task automatic cycle();
    fetch_entry_t e;
    @(negedge clk);
    check("valid", issue_valid, q.size() > 0);
    if (q.size() > 0) begin
      e = q[0];
      check("instr", instr, e.instr);
      check("issue_pc", issue_pc, e.pc);
      check("op", op, e.instr[OP_MSB:OP_LSB]);
      check("funct", funct, e.instr[FUNCT_MSB:FUNCT_LSB]);
      if (e.pc == 32'h8) seen_op8 = {op, funct};
    end
    if (imem_req) begin
      if (!active) begin
        check("req_addr", imem_addr, exp_pc);
        check("req_slot", q.size() < DEPTH, 1);
        active = 1;
        held = imem_addr;
      end else begin
        check("req_hold", imem_addr, held);
      end
    end

    imem_ack = 1'b0;
    redirect = 1'b0;
    issue_ready = ($urandom_range(99) < ready_pct);
    if (imem_req) begin
      if (mem_cnt == 0) mem_cnt = (lat_cfg == 0) ? int'($urandom_range(3, 1)) : lat_cfg;
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_rdata = $urandom();
      end
    end

    case (redir_mode)
      1: if (imem_req && !imem_ack) redirect = 1'b1;
      2: if (imem_ack && issue_valid) begin redirect = 1'b1; issue_ready = 1'b1; end
      4: redirect = 1'b1;
      default: ;
    endcase
    if (redirect) begin
      redirect_target = redir_tgt;
      redir_hit = 1;
      redir_mode = 0;
      issued.delete();
    end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
      redirect = 1'b1;
      redirect_target = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                                 : ($urandom() & 32'hFFFF_FFFC);
    end

    if (redirect) begin
      q.delete();
      exp_pc = redirect_target;
      if (imem_ack) stale = 0;
      else if (imem_req) stale = 1;
    end else begin
      if (q.size() > 0 && issue_ready) begin
        issued.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (imem_ack) begin
        if (stale) stale = 0;
        else begin
          q.push_back('{pc: exp_pc, instr: imem_rdata});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    if (imem_ack) active = 0;
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, issue_valid, 0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_op"}, op, 4'h0);
    check({tag, "_funct"}, funct, 4'h0);
    check({tag, "_pc"}, issue_pc, 32'h0);
  endtask

  task automatic do_reset(input bit ack_in_reset);
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b0;
    imem_ack = 1'b0;
    issue_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    if (ack_in_reset) begin
      @(negedge clk);
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      check_reset_outputs("rst_ack");
    end
    repeat (2) @(negedge clk);
    q.delete();
    issued.delete();
    exp_pc = 32'h0;
    stale = 0;
    active = 0;
    mem_cnt = 0;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    salt = $urandom();
    do_reset(0);

    // 1: zero-wait memory, always ready
    lat_cfg = 1; ready_pct = 100;
    repeat (40) cycle();
    check("t1_progress", issued.size() >= 10, 1);
    for (int i = 0; i < 4; i++) check("t1_seq", pc_at(i), 32'(4 * i));
    check("t1_opfunct", {24'h0, seen_op8}, 32'h25);

    // 2: stall issue until the buffer fills
    ready_pct = 0;
    repeat (12) cycle();
    #1;
    check("t2_count", q.size(), DEPTH);
    check("t2_valid", issue_valid, 1);
    check("t2_req_low", imem_req, 0);
    base = exp_pc - 32'd16;
    issued.delete();
    ready_pct = 100;
    repeat (20) cycle();
    for (int i = 0; i < 4; i++) check("t2_order", pc_at(i), base + 32'(4 * i));
    check("t2_resume", issued.size() >= 6, 1);

    // 3: slow memory, redirect while request outstanding
    lat_cfg = 3;
    redir_hit = 0; redir_tgt = 32'h100; redir_mode = 1;
    for (int i = 0; i < 20 && !redir_hit; i++) cycle();
    check("t3_hit", redir_hit, 1);
    #1;
    check("t3_empty", issue_valid, 0);
    repeat (30) cycle();
    check("t3_first", pc_at(0), 32'h100);

    // 4: redirect on the same edge as pop and ack
    lat_cfg = 1; ready_pct = 0;
    repeat (3) cycle();
    redir_hit = 0; redir_tgt = 32'h200; redir_mode = 2;
    for (int i = 0; i < 20 && !redir_hit; i++) cycle();
    check("t4_hit", redir_hit, 1);
    #1;
    check("t4_empty", issue_valid, 0);
    ready_pct = 100;
    repeat (12) cycle();
    check("t4_first", pc_at(0), 32'h200);

    // 5: address wrap
    redir_hit = 0; redir_tgt = 32'hFFFF_FFFC; redir_mode = 4;
    cycle();
    repeat (14) cycle();
    check("t5_hit", redir_hit, 1);
    check("t5_top", pc_at(0), 32'hFFFF_FFFC);
    check("t5_wrap", pc_at(1), 32'h0);
    check("t5_next", pc_at(2), 32'h4);

    // 6: reset during an outstanding request
    lat_cfg = 3;
    for (int i = 0; i < 20; i++) begin
      cycle();
      #1;
      if (imem_req) break;
    end
    check("t6_req", imem_req, 1);
    do_reset(1);
    lat_cfg = 1;
    repeat (10) cycle();
    check("t6_first", pc_at(0), 32'h0);

    // random mix of latency, backpressure and redirects
    lat_cfg = 0; ready_pct = 60; redir_pct = 3;
    repeat (3000) cycle();
    redir_pct = 0; ready_pct = 100;
    repeat (20) cycle();
    check("rand_progress", issued.size() > 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
